// File: rtl/riscv_pkg.sv
// Shared core types: fetch FSM encoding, instruction size and the default boot PC.
package riscv_pkg;

   typedef enum logic [1:0] {
      REQ    = 2'd0,
      WAIT   = 2'd1,
      HOLD   = 2'd2,
      SQUASH = 2'd3
   } fetch_state_t;

   localparam int          INSN_BYTES           = 4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer.sv
// Architectural PC owner: issues one imem request at a time, hands the word to decode,
// and squashes in-flight fetches when the branch unit redirects.
module fetch_sequencer
   import riscv_pkg::*;
#(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instruction,
   output logic            misalign_err,
   output logic [31:0]     fetch_count
);

   localparam logic [1:0] ST_REQ    = REQ;
   localparam logic [1:0] ST_WAIT   = WAIT;
   localparam logic [1:0] ST_HOLD   = HOLD;
   localparam logic [1:0] ST_SQUASH = SQUASH;

   logic [1:0]      state, state_nx;
   logic [XLEN-1:0] pc, pc_nx;
   logic [XLEN-1:0] redir_pc;
   logic            hs;
   logic            load_if;
   logic            count_inc;

   assign imem_req_valid = (state == ST_REQ) && !stall && !rst;
   assign imem_addr      = pc;
   assign if_valid       = (state == ST_HOLD);
   assign hs             = imem_req_valid && imem_req_ready;
   assign redir_pc       = {redirect_pc[XLEN-1:2], 2'b00};

   // Redirect outranks every other event; a response racing a redirect is dropped.
   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      load_if   = 1'b0;
      count_inc = 1'b0;
      case (state)
         ST_REQ: begin
            if (redirect_valid) begin
               pc_nx    = redir_pc;
               state_nx = hs ? ST_SQUASH : ST_REQ;
            end else if (hs) begin
               state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_nx    = redir_pc;
               state_nx = imem_resp_valid ? ST_REQ : ST_SQUASH;
            end else if (imem_resp_valid) begin
               load_if  = 1'b1;
               pc_nx    = pc + XLEN'(INSN_BYTES);
               state_nx = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               pc_nx    = redir_pc;
               state_nx = ST_REQ;
            end else if (if_ready) begin
               count_inc = 1'b1;
               state_nx  = ST_REQ;
            end
         end
         default: begin
            // SQUASH: wait out the orphaned response; a later redirect just retargets.
            if (redirect_valid) pc_nx = redir_pc;
            if (imem_resp_valid) state_nx = ST_REQ;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_REQ;
         pc             <= RESET_VECTOR;
         if_pc          <= '0;
         if_instruction <= '0;
         misalign_err   <= 1'b0;
         fetch_count    <= '0;
      end else begin
         state        <= state_nx;
         pc           <= pc_nx;
         misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (load_if) begin
            if_pc          <= pc;
            if_instruction <= imem_resp_data;
         end
         if (count_inc) fetch_count <= fetch_count + 32'd1;
      end
   end

   a_resp_protocol: assert property (@(posedge clk) disable iff (rst)
      imem_resp_valid |-> (state == ST_WAIT || state == ST_SQUASH));

endmodule
